hash_table_cmd_master: RTL and testbench
========================================

Name: hash_table_cmd_master

Overview:
- Hardware initiator for the hash_table op interface (op_en/op_sel/key_in/value_in in; value_out/op_done/op_error out).
- Accepts insert/delete/search requests from an upstream valid/ready channel and issues them one at a time to the table.
- Returns each result on a valid/ready response channel, guards against a hung table with a timeout, and keeps saturating op/error statistics.
- Sits between a host/CSR front end and hash_table.

Parameters:
- KEY_WIDTH, 32, key width; matches hash_table.
- VALUE_WIDTH, 32, value width; matches hash_table.
- TIMEOUT_CYCLES, 64, max cycles op_en is held waiting for ht_op_done; must be >= 2.
- CNT_WIDTH, 16, width of statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_op  in  2  00 insert, 01 delete, 10 search, 11 illegal
- req_key  in  KEY_WIDTH  request key
- req_value  in  VALUE_WIDTH  insert value (ignored otherwise)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_op  out  2  echo of accepted req_op
- rsp_value  out  VALUE_WIDTH  search result; 0 for insert/delete/error
- rsp_error  out  1  table op_error, illegal op, or timeout
- rsp_timeout  out  1  error was caused by timeout
- ht_key  out  KEY_WIDTH  to hash_table key_in
- ht_value  out  VALUE_WIDTH  to hash_table value_in
- ht_op_sel  out  2  to hash_table op_sel
- ht_op_en  out  1  to hash_table op_en
- ht_value_out  in  VALUE_WIDTH  from hash_table value_out
- ht_op_done  in  1  from hash_table op_done
- ht_op_error  in  1  from hash_table op_error
- op_count  out  CNT_WIDTH  completed responses, saturating
- err_count  out  CNT_WIDTH  responses with rsp_error=1, saturating

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high. All outputs registered.
- Reset: state IDLE. req_ready=1, rsp_valid=0, rsp_op=0, rsp_value=0, rsp_error=0, rsp_timeout=0, ht_op_en=0, ht_key=0, ht_value=0, ht_op_sel=0, op_count=0, err_count=0, timer=0. Reset mid-operation drops ht_op_en the next cycle and discards the in-flight request; no response is produced.
- FSM states: IDLE, ISSUE, RELEASE, RESP.
- IDLE: req_ready=1. On accept:
  - Legal op: latch key/value/op into ht_* and assert ht_op_en next cycle. Clear timer. Go to ISSUE.
  - req_op=11: do not touch the ht_* bus. Load rsp_error=1, rsp_value=0. Go to RESP.
  - req_ready drops the cycle after accept.
- ISSUE: ht_op_en=1; ht_key, ht_value and ht_op_sel held stable. Timer increments each cycle.
  - ht_op_done=1 sampled: capture ht_op_error into rsp_error. rsp_value = ht_value_out if op=10 and no error, else 0. rsp_timeout=0. Deassert ht_op_en. Go to RELEASE.
  - Timer reaches TIMEOUT_CYCLES-1 without done: deassert ht_op_en. rsp_error=1, rsp_timeout=1, rsp_value=0. Go to RELEASE.
  - ht_op_done and timeout in the same cycle: done wins.
- RELEASE: exactly one cycle with ht_op_en=0, which guarantees the table sees an op_en low gap between ops. Then go to RESP with rsp_valid=1.
  - The illegal-op path goes IDLE -> RESP directly; rsp_valid=1 one cycle after accept.
- RESP: rsp_valid held and rsp_* stable until rsp_ready.
  - On handshake: rsp_valid=0; op_count+=1 and err_count+=rsp_error, both saturating at all ones. req_ready=1 next cycle. Go to IDLE.
  - rsp_ready held high continuously is legal and gives back-to-back throughput.
- ht_op_done seen in IDLE, RELEASE or RESP (stale or late) is ignored.
- Minimum latency, legal op, table done 1 cycle after op_en rises: accept edge T -> op_en high T+1 -> done sampled T+2 -> rsp_valid T+3.
- Single outstanding request; no reordering.

Test Plan:
- Insert key=1 value=2 (table done 2 cycles after op_en, error=0) -> ht_op_sel=00, ht_key=1, ht_value=2 while op_en=1. rsp_op=00, rsp_error=0, rsp_value=0. op_count=1.
- Search key=1 (table returns value_out=2, error=0) -> rsp_value=2, rsp_error=0. Then search key=7 with table error=1 -> rsp_error=1, rsp_value=0, err_count=1.
- req_op=11, key=5 -> ht_op_en never asserts. rsp_valid one cycle after accept with rsp_error=1, rsp_timeout=0.
- TIMEOUT_CYCLES=8, table never asserts done -> ht_op_en high exactly 8 cycles, then low. rsp_error=1, rsp_timeout=1.
- Back-to-back: insert(3,2), then delete(1) with rsp_ready tied 1 -> ht_op_en low for at least 1 cycle between ops. Second op carries ht_op_sel=01, ht_key=1. Hold rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0 throughout.
- Assert rst while in ISSUE -> next cycle ht_op_en=0, rsp_valid=0, req_ready=1, counters 0. A late ht_op_done produces no response.

Source files
------------

// File: rtl/hash_table_cmd_master.sv
// Command master for hash_table: takes one request at a time, drives the table op bus,
// returns the result on a response channel, and keeps saturating op/error counters.
module hash_table_cmd_master #(
   parameter int KEY_WIDTH      = 32,
   parameter int VALUE_WIDTH    = 32,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             req_op,
   input  logic [KEY_WIDTH-1:0]   req_key,
   input  logic [VALUE_WIDTH-1:0] req_value,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [1:0]             rsp_op,
   output logic [VALUE_WIDTH-1:0] rsp_value,
   output logic                   rsp_error,
   output logic                   rsp_timeout,
   output logic [KEY_WIDTH-1:0]   ht_key,
   output logic [VALUE_WIDTH-1:0] ht_value,
   output logic [1:0]             ht_op_sel,
   output logic                   ht_op_en,
   input  logic [VALUE_WIDTH-1:0] ht_value_out,
   input  logic                   ht_op_done,
   input  logic                   ht_op_error,
   output logic [CNT_WIDTH-1:0]   op_count,
   output logic [CNT_WIDTH-1:0]   err_count,
   output logic [1:0]             dbg_state
);

   // Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1;
   // the sender keeps valid and payload stable until that edge.

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RELEASE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t                 state, state_d;
   logic [TW-1:0]          timer, timer_d;
   logic                   req_ready_d, rsp_valid_d, rsp_error_d, rsp_timeout_d, ht_op_en_d;
   logic [1:0]             rsp_op_d, ht_op_sel_d;
   logic [VALUE_WIDTH-1:0] rsp_value_d, ht_value_d;
   logic [KEY_WIDTH-1:0]   ht_key_d;
   logic [CNT_WIDTH-1:0]   op_count_d, err_count_d;

   assign dbg_state = state;

   always_comb begin
      state_d       = state;
      timer_d       = timer;
      req_ready_d   = req_ready;
      rsp_valid_d   = rsp_valid;
      rsp_op_d      = rsp_op;
      rsp_value_d   = rsp_value;
      rsp_error_d   = rsp_error;
      rsp_timeout_d = rsp_timeout;
      ht_key_d      = ht_key;
      ht_value_d    = ht_value;
      ht_op_sel_d   = ht_op_sel;
      ht_op_en_d    = ht_op_en;
      op_count_d    = op_count;
      err_count_d   = err_count;

      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               req_ready_d = 1'b0;
               rsp_op_d    = req_op;
               if (req_op == 2'b11) begin
                  // Illegal op never reaches the table bus
                  rsp_error_d   = 1'b1;
                  rsp_timeout_d = 1'b0;
                  rsp_value_d   = '0;
                  rsp_valid_d   = 1'b1;
                  state_d       = RESP;
               end else begin
                  ht_key_d    = req_key;
                  ht_value_d  = req_value;
                  ht_op_sel_d = req_op;
                  ht_op_en_d  = 1'b1;
                  timer_d     = '0;
                  state_d     = ISSUE;
               end
            end
         end

         ISSUE: begin
            // A done on the final timer cycle still counts as a normal completion
            if (ht_op_done) begin
               rsp_error_d   = ht_op_error;
               rsp_timeout_d = 1'b0;
               rsp_value_d   = (ht_op_sel == 2'b10 && !ht_op_error) ? ht_value_out : '0;
               ht_op_en_d    = 1'b0;
               state_d       = RELEASE;
            end else if (timer == TMAX) begin
               rsp_error_d   = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_value_d   = '0;
               ht_op_en_d    = 1'b0;
               state_d       = RELEASE;
            end else begin
               timer_d = timer + 1'b1;
            end
         end

         RELEASE: begin
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end

         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               if (op_count != {CNT_WIDTH{1'b1}})
                  op_count_d = op_count + 1'b1;
               if (rsp_error && err_count != {CNT_WIDTH{1'b1}})
                  err_count_d = err_count + 1'b1;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         timer       <= '0;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_op      <= '0;
         rsp_value   <= '0;
         rsp_error   <= 1'b0;
         rsp_timeout <= 1'b0;
         ht_key      <= '0;
         ht_value    <= '0;
         ht_op_sel   <= '0;
         ht_op_en    <= 1'b0;
         op_count    <= '0;
         err_count   <= '0;
      end else begin
         state       <= state_d;
         timer       <= timer_d;
         req_ready   <= req_ready_d;
         rsp_valid   <= rsp_valid_d;
         rsp_op      <= rsp_op_d;
         rsp_value   <= rsp_value_d;
         rsp_error   <= rsp_error_d;
         rsp_timeout <= rsp_timeout_d;
         ht_key      <= ht_key_d;
         ht_value    <= ht_value_d;
         ht_op_sel   <= ht_op_sel_d;
         ht_op_en    <= ht_op_en_d;
         op_count    <= op_count_d;
         err_count   <= err_count_d;
      end
   end

endmodule

// File: tb/tb_hash_table_cmd_master.sv
// Bench for hash_table_cmd_master: table-driven single ops against a scripted table model,
// plus back-to-back, counter saturation and mid-op reset sequences.
module tb_hash_table_cmd_master;

   localparam int KW = 32;
   localparam int VW = 32;
   localparam int TO = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready;
   logic [1:0]    req_op;
   logic [KW-1:0] req_key;
   logic [VW-1:0] req_value;
   logic          rsp_valid, rsp_ready;
   logic [1:0]    rsp_op;
   logic [VW-1:0] rsp_value;
   logic          rsp_error, rsp_timeout;
   logic [KW-1:0] ht_key;
   logic [VW-1:0] ht_value;
   logic [1:0]    ht_op_sel;
   logic          ht_op_en;
   logic [VW-1:0] ht_value_out;
   logic          ht_op_done, ht_op_error;
   logic [CW-1:0] op_count, err_count;
   logic [1:0]    dbg_state;

   int checks = 0;
   int failures = 0;
   logic [CW-1:0] exp_op = '0;
   logic [CW-1:0] exp_err = '0;

   hash_table_cmd_master #(
      .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_key(req_key), .req_value(req_value),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
      .rsp_value(rsp_value), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
      .ht_key(ht_key), .ht_value(ht_value), .ht_op_sel(ht_op_sel), .ht_op_en(ht_op_en),
      .ht_value_out(ht_value_out), .ht_op_done(ht_op_done), .ht_op_error(ht_op_error),
      .op_count(op_count), .err_count(err_count), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]    op;
      logic [KW-1:0] key;
      logic [VW-1:0] val;
      int            delay;   // op_en cycle on which table raises done; 0 = never
      logic          t_err;
      logic [VW-1:0] t_val;
      int            hold;    // cycles rsp_ready held low
      logic [VW-1:0] e_val;
      logic          e_err;
      logic          e_to;
      int            e_en;    // expected op_en high cycles
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_count(input logic err);
      if (exp_op != {CW{1'b1}}) exp_op = exp_op + 1'b1;
      if (err && exp_err != {CW{1'b1}}) exp_err = exp_err + 1'b1;
   endtask

   task automatic check_rsp(input string tag, input vec_t v);
      chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, ".req_ready_low"}, 64'(req_ready), 64'd0);
      chk({tag, ".rsp_op"}, 64'(rsp_op), 64'(v.op));
      chk({tag, ".rsp_value"}, 64'(rsp_value), 64'(v.e_val));
      chk({tag, ".rsp_error"}, 64'(rsp_error), 64'(v.e_err));
      chk({tag, ".rsp_timeout"}, 64'(rsp_timeout), 64'(v.e_to));
   endtask

   // driver: one request, scripted table response, response drain
   task automatic do_op(input string tag, input vec_t v);
      int en_cycles;
      logic bus_ok;
      @(negedge clk);
      chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_op    = v.op;
      req_key   = v.key;
      req_value = v.val;
      ht_value_out = v.t_val;
      @(negedge clk);
      req_valid = 1'b0;
      if (v.op == 2'b11) begin
         chk({tag, ".illegal_no_en"}, 64'(ht_op_en), 64'd0);
      end else begin
         en_cycles = 0;
         bus_ok = 1'b1;
         while (ht_op_en && en_cycles < 20) begin
            en_cycles++;
            if (ht_key !== v.key || ht_value !== v.val || ht_op_sel !== v.op) bus_ok = 1'b0;
            ht_op_done  = (en_cycles == v.delay);
            ht_op_error = v.t_err;
            @(negedge clk);
         end
         ht_op_done = 1'b0;
         chk({tag, ".en_cycles"}, 64'(en_cycles), 64'(v.e_en));
         chk({tag, ".bus_stable"}, 64'(bus_ok), 64'd1);
         chk({tag, ".release_state"}, 64'(dbg_state), 64'd2);
         chk({tag, ".release_no_rsp"}, 64'(rsp_valid), 64'd0);
         @(negedge clk);
      end
      check_rsp(tag, v);
      for (int i = 0; i < v.hold; i++) begin
         ht_op_done = 1'b1;  // stale done while waiting must be ignored
         @(negedge clk);
         check_rsp({tag, ".hold"}, v);
      end
      ht_op_done = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      model_count(v.e_err);
      chk({tag, ".rsp_done"}, 64'(rsp_valid), 64'd0);
      chk({tag, ".req_ready_back"}, 64'(req_ready), 64'd1);
      chk({tag, ".op_count"}, 64'(op_count), 64'(exp_op));
      chk({tag, ".err_count"}, 64'(err_count), 64'(exp_err));
   endtask

   initial begin
      vec_t ill;
      int gap;
      logic [1:0] gap_rsp_op;
      logic gap_rsp_seen, quiet;

      //            op     key           val           dly err  t_val         hold e_val         e_err e_to e_en
      vecs[0] = '{2'b00, 32'd1,        32'd2,        2, 1'b0, 32'hDEAD,     0, 32'd0,        1'b0, 1'b0, 2};
      vecs[1] = '{2'b10, 32'd1,        32'd0,        1, 1'b0, 32'd2,        2, 32'd2,        1'b0, 1'b0, 1};
      vecs[2] = '{2'b10, 32'd7,        32'd0,        3, 1'b1, 32'h55,       0, 32'd0,        1'b1, 1'b0, 3};
      vecs[3] = '{2'b11, 32'd5,        32'd9,        0, 1'b0, 32'd0,        1, 32'd0,        1'b1, 1'b0, 0};
      vecs[4] = '{2'b01, 32'd9,        32'd0,        0, 1'b0, 32'd0,        5, 32'd0,        1'b1, 1'b1, 8};
      vecs[5] = '{2'b10, 32'h12345678, 32'd0,        8, 1'b0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b0, 1'b0, 8};
      vecs[6] = '{2'b01, 32'hFFFFFFFF, 32'd0,        1, 1'b1, 32'd0,        0, 32'd0,        1'b1, 1'b0, 1};
      vecs[7] = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 4, 1'b0, 32'd0,        0, 32'd0,        1'b0, 1'b0, 4};

      rst = 1'b1;
      req_valid = 1'b0; req_op = '0; req_key = '0; req_value = '0;
      rsp_ready = 1'b0;
      ht_value_out = '0; ht_op_done = 1'b0; ht_op_error = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst.state", 64'(dbg_state), 64'd0);
      chk("rst.req_ready", 64'(req_ready), 64'd1);
      chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst.rsp_fields", {rsp_op, rsp_error, rsp_timeout}, 64'd0);
      chk("rst.rsp_value", 64'(rsp_value), 64'd0);
      chk("rst.ht_op_en", 64'(ht_op_en), 64'd0);
      chk("rst.ht_bus", {ht_key, ht_value}, 64'd0);
      chk("rst.counters", {op_count, err_count}, 64'd0);

      for (int i = 0; i < 8; i++) do_op($sformatf("vec%0d", i), vecs[i]);

      // back-to-back insert(3,2) then delete(1) with rsp_ready tied high
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("b2b.req_ready", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_op = 2'b00; req_key = 32'd3; req_value = 32'd2;
      @(negedge clk);
      chk("b2b.first_en", 64'(ht_op_en), 64'd1);
      chk("b2b.first_bus", {ht_op_sel, ht_key[15:0], ht_value[15:0]}, {2'b00, 16'd3, 16'd2});
      req_op = 2'b01; req_key = 32'd1; req_value = 32'd0;
      ht_op_done = 1'b1; ht_op_error = 1'b0;
      @(negedge clk);
      ht_op_done = 1'b0;
      gap = 0; gap_rsp_seen = 1'b0; gap_rsp_op = 2'b11;
      while (!ht_op_en && gap < 20) begin
         gap++;
         if (rsp_valid) begin
            gap_rsp_seen = 1'b1;
            gap_rsp_op = rsp_op;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      model_count(1'b0);
      chk("b2b.en_gap", 64'(gap), 64'd3);
      chk("b2b.first_rsp", {gap_rsp_seen, gap_rsp_op}, {1'b1, 2'b00});
      chk("b2b.second_bus", {ht_op_en, ht_op_sel, ht_key}, {1'b1, 2'b01, 32'd1});
      ht_op_done = 1'b1;
      @(negedge clk);
      ht_op_done = 1'b0;
      chk("b2b.second_release", 64'(ht_op_en), 64'd0);
      @(negedge clk);
      chk("b2b.second_rsp", {rsp_valid, rsp_op, rsp_error}, {1'b1, 2'b01, 1'b0});
      @(negedge clk);
      model_count(1'b0);
      chk("b2b.drained", 64'(rsp_valid), 64'd0);
      chk("b2b.op_count", 64'(op_count), 64'(exp_op));
      rsp_ready = 1'b0;

      // saturation via illegal ops (counters are CW bits wide)
      ill = vecs[3];
      ill.hold = 0;
      for (int i = 0; i < 11; i++) do_op($sformatf("sat%0d", i), ill);
      chk("sat.op_count", 64'(op_count), 64'hF);
      chk("sat.err_count", 64'(err_count), 64'hF);

      // reset mid-ISSUE, then a late done must produce nothing
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b00; req_key = 32'h42; req_value = 32'h43;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("mid.in_issue", 64'(ht_op_en), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid.en_dropped", 64'(ht_op_en), 64'd0);
      chk("mid.rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mid.req_ready", 64'(req_ready), 64'd1);
      chk("mid.counters", {op_count, err_count}, 64'd0);
      ht_op_done = 1'b1;
      @(negedge clk);
      ht_op_done = 1'b0;
      quiet = 1'b1;
      repeat (4) begin
         if (rsp_valid || ht_op_en || dbg_state != 2'd0) quiet = 1'b0;
         @(negedge clk);
      end
      chk("mid.late_done_ignored", 64'(quiet), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
